// File: rtl/puf_pkg.sv
// Shared definitions for the RO-PUF race controller.
//   state_t     : controller FSM states
//   LFSR_TAPS   : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   SEED_SUBST  : seed used in place of an all-zero challenge
//   sel_width() : RO select width derived from the oscillator count
//   lfsr_step() : one LFSR advance (shift left, feedback into bit 0)
package puf_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StSettle,
        StRace,
        StRecord,
        StNext,
        StDone
    } state_t;

    // Tap n maps to bit n-1: bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] SEED_SUBST = 16'h0001;

    function automatic int unsigned sel_width(input int unsigned num_ro);
        return (num_ro > 1) ? $clog2(num_ro) : 1;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/puf_lfsr.sv
// 16-bit Fibonacci LFSR used to walk the RO pair sequence.
// Ports:
//   clk, rst : clock, synchronous active-high reset (state -> 0)
//   load     : load seed (has priority over advance)
//   seed     : value loaded on load
//   advance  : step the LFSR once
//   state    : current LFSR contents
module puf_lfsr
    import puf_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= 16'h0000;
        end else if (load) begin
            state <= seed;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/puf_race_ctrl.sv
// RO-PUF race controller: derives RO pairs from an LFSR seeded by the
// challenge, clears/settles/races the two edge counters per bit and
// assembles the response word.
// Optional build macro PUF_MAJORITY_EN: each bit is raced three times on
// the same pair and the majority outcome is recorded.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin evaluation (honoured only in idle)
//   challenge       : LFSR seed, captured on accepted start
//   done_a, done_b  : counter A/B reached threshold (looked at only in race)
//   sel_a, sel_b    : RO indices routed to counters A/B
//   ro_en           : RO and counter enable
//   ctr_clr         : counter clear pulse
//   busy            : high outside idle
//   resp_valid      : one-cycle pulse with a fresh response
//   response        : response word, held until the next resp_valid
//   err             : a race tied or timed out during this evaluation
module puf_race_ctrl
    import puf_pkg::*;
#(
    parameter int unsigned NUM_RO        = 16,
    parameter int unsigned RESP_BITS     = 8,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 65535,
    localparam int unsigned SEL_W        = sel_width(NUM_RO)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          challenge,
    input  logic                 done_a,
    input  logic                 done_b,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    output logic                 ro_en,
    output logic                 ctr_clr,
    output logic                 busy,
    output logic                 resp_valid,
    output logic [RESP_BITS-1:0] response,
    output logic                 err
);

    localparam int unsigned CNT_MAX = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int unsigned PAIR_W  = 2 * SEL_W;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [RESP_BITS-1:0] resp_sr;
    logic                 race_bit;
    logic                 race_bad;

    logic [15:0]          seed_eff;
    logic [15:0]          lfsr_state;
    logic                 lfsr_load;
    logic                 lfsr_adv;
    logic [PAIR_W-1:0]    seed_src;
    logic [PAIR_W-1:0]    next_src;

    // Returns {sel_b, sel_a}; a colliding pair gets sel_b = sel_a ^ 1.
    function automatic logic [PAIR_W-1:0] derive_pair(input logic [PAIR_W-1:0] v);
        logic [SEL_W-1:0] a;
        logic [SEL_W-1:0] b;
        a = v[SEL_W-1:0];
        b = v[PAIR_W-1:SEL_W];
        if (b == a) b = a ^ SEL_W'(1);
        return {b, a};
    endfunction

    assign seed_eff  = (challenge == 16'h0000) ? SEED_SUBST : challenge;
    assign lfsr_load = (state == StIdle) && start;
    assign lfsr_adv  = (state == StNext);
    assign seed_src  = PAIR_W'(seed_eff);
    // The pair registers update in the same cycle the LFSR advances.
    assign next_src  = PAIR_W'(lfsr_step(lfsr_state));

    puf_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .seed    (seed_eff),
        .advance (lfsr_adv),
        .state   (lfsr_state)
    );

`ifdef PUF_MAJORITY_EN
    logic [1:0] rep;
    logic [1:0] votes;
    logic [1:0] votes_sum;
    assign votes_sum = votes + {1'b0, race_bit};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            cnt        <= '0;
            idx        <= '0;
            resp_sr    <= '0;
            race_bit   <= 1'b0;
            race_bad   <= 1'b0;
            sel_a      <= '0;
            sel_b      <= '0;
            ro_en      <= 1'b0;
            ctr_clr    <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            response   <= '0;
            err        <= 1'b0;
`ifdef PUF_MAJORITY_EN
            rep        <= '0;
            votes      <= '0;
`endif
        end else begin
            ctr_clr    <= 1'b0;
            resp_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state          <= StClear;
                        ctr_clr        <= 1'b1;
                        busy           <= 1'b1;
                        err            <= 1'b0;
                        idx            <= '0;
                        resp_sr        <= '0;
                        {sel_b, sel_a} <= derive_pair(seed_src);
`ifdef PUF_MAJORITY_EN
                        rep            <= '0;
                        votes          <= '0;
`endif
                    end
                end
                StClear: begin
                    state <= StSettle;
                    cnt   <= '0;
                end
                StSettle: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state <= StRace;
                        cnt   <= '0;
                        ro_en <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StRace: begin
                    // A done in the final cycle wins over the timeout.
                    if (done_a || done_b || cnt == CNT_W'(TIMEOUT - 1)) begin
                        state    <= StRecord;
                        ro_en    <= 1'b0;
                        race_bit <= done_a & ~done_b;
                        race_bad <= (done_a & done_b) | ~(done_a | done_b);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StRecord: begin
                    if (race_bad) err <= 1'b1;
`ifdef PUF_MAJORITY_EN
                    if (rep == 2'd2) begin
                        resp_sr[idx] <= (votes_sum >= 2'd2);
                        rep          <= '0;
                        votes        <= '0;
                        state        <= StNext;
                    end else begin
                        rep     <= rep + 1'b1;
                        votes   <= votes_sum;
                        state   <= StClear;
                        ctr_clr <= 1'b1;
                    end
`else
                    resp_sr[idx] <= race_bit;
                    state        <= StNext;
`endif
                end
                StNext: begin
                    {sel_b, sel_a} <= derive_pair(next_src);
                    idx            <= idx + 1'b1;
                    if (idx == IDX_W'(RESP_BITS - 1)) begin
                        state      <= StDone;
                        resp_valid <= 1'b1;
                        response   <= resp_sr;
                    end else begin
                        state   <= StClear;
                        ctr_clr <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_race_ctrl.sv
// Randomized self-checking bench for puf_race_ctrl (TIMEOUT shortened to 20).
module tb_puf_race_ctrl;

    localparam int TO = 20;
    localparam int RB = 8;
    localparam int ST = 4;
`ifdef PUF_MAJORITY_EN
    localparam int REPS = 3;
`else
    localparam int REPS = 1;
`endif
    localparam int NRACE = RB * REPS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] challenge = 16'h0000;
    logic        done_a = 1'b0;
    logic        done_b = 1'b0;
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic        ro_en;
    logic        ctr_clr;
    logic        busy;
    logic        resp_valid;
    logic [7:0]  response;
    logic        err;

    puf_race_ctrl #(
        .NUM_RO        (16),
        .RESP_BITS     (RB),
        .SETTLE_CYCLES (ST),
        .TIMEOUT       (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .challenge  (challenge),
        .done_a     (done_a),
        .done_b     (done_b),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .ro_en      (ro_en),
        .ctr_clr    (ctr_clr),
        .busy       (busy),
        .resp_valid (resp_valid),
        .response   (response),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Race plan: kind 0 = A wins, 1 = B wins, 2 = tie, 3 = nobody (timeout).
    int         kind    [NRACE];
    int         dly     [NRACE];
    int         exp_len [NRACE];
    int         exp_a   [RB];
    int         exp_b   [RB];
    logic [7:0] exp_resp;
    logic       exp_err;
    int         exp_cycles;
    logic [7:0] last_resp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lfsr_model(input int v);
        int taps [4] = '{16, 14, 13, 11};
        int fb = 0;
        foreach (taps[i]) fb = fb ^ ((v >> (taps[i] - 1)) & 1);
        return ((v << 1) | fb) & 32'hFFFF;
    endfunction

    task automatic build_expect(input logic [15:0] seed);
        int v;
        int ones;
        int len;
        v          = (seed == 16'h0) ? 1 : int'(seed);
        exp_cycles = 0;
        exp_err    = 1'b0;
        exp_resp   = 8'h00;
        for (int b = 0; b < RB; b++) begin
            exp_a[b] = v % 16;
            exp_b[b] = (v / 16) % 16;
            if (exp_b[b] == exp_a[b]) exp_b[b] = exp_a[b] ^ 1;
            ones = 0;
            for (int k = 0; k < REPS; k++) begin
                int r;
                r = b * REPS + k;
                if (kind[r] == 0) ones++;
                if (kind[r] >= 2) exp_err = 1'b1;
                len        = (kind[r] == 3) ? TO : dly[r] + 1;
                exp_len[r] = len;
                exp_cycles += 1 + ST + len + 1;
            end
            exp_resp[b] = (2 * ones > REPS);
            exp_cycles += 1;
            v = lfsr_model(v);
        end
    endtask

    task automatic plan_all(input int k, input int d);
        for (int r = 0; r < NRACE; r++) begin
            kind[r] = k;
            dly[r]  = (d < 0) ? int'($urandom_range(0, 15)) : d;
        end
    endtask

    task automatic plan_random(input bit allow_bad);
        for (int r = 0; r < NRACE; r++) begin
            int x;
            x = int'($urandom_range(0, 9));
            if (allow_bad && x == 0)      kind[r] = 2;
            else if (allow_bad && x == 1) kind[r] = 3;
            else                          kind[r] = x % 2;
            dly[r] = int'($urandom_range(0, 15));
        end
    endtask

    // Runs one evaluation; if rst_race >= 0, reset is applied 3 cycles into that race.
    task automatic run_eval(input logic [15:0] seed, input int rst_race);
        int cyc;
        int r;
        int rc;
        int nclr;
        int rr;
        bit got;
        build_expect(seed);
        check_eq("resp_held", response, last_resp);
        challenge = seed;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        check_eq("err_cleared", err, 0);
        cyc  = 0;
        r    = 0;
        rc   = 0;
        nclr = 0;
        got  = 1'b0;
        while (!got && cyc <= exp_cycles + 8) begin
            rr = (r < NRACE) ? r : NRACE - 1;
            if (ctr_clr) nclr++;
            if (ro_en) begin
                if (rc == 0) begin
                    check_eq("sel_a", sel_a, exp_a[rr / REPS]);
                    check_eq("sel_b", sel_b, exp_b[rr / REPS]);
                    check_eq("pair_distinct", sel_a != sel_b, 1);
                end
                if (r == rst_race && rc == 3) begin
                    rst    = 1'b1;
                    start  = 1'b0;
                    done_a = 1'b0;
                    done_b = 1'b0;
                    @(posedge clk);
                    #1;
                    check_eq("rst_busy", busy, 0);
                    check_eq("rst_ro_en", ro_en, 0);
                    check_eq("rst_response", response, 0);
                    check_eq("rst_resp_valid", resp_valid, 0);
                    check_eq("rst_err", err, 0);
                    rst       = 1'b0;
                    last_resp = 8'h00;
                    nclr      = 0;
                    for (int i = 0; i < 6; i++) begin
                        done_a = 1'($urandom_range(0, 1));
                        done_b = 1'($urandom_range(0, 1));
                        if (resp_valid || busy) nclr++;
                        @(posedge clk);
                        #1;
                    end
                    check_eq("rst_quiet", nclr, 0);
                    done_a = 1'b0;
                    done_b = 1'b0;
                    return;
                end
                done_a = 1'b0;
                done_b = 1'b0;
                if (kind[rr] != 3 && rc == dly[rr]) begin
                    done_a = (kind[rr] == 0 || kind[rr] == 2);
                    done_b = (kind[rr] == 1 || kind[rr] == 2);
                end
                rc++;
            end else begin
                if (rc != 0) begin
                    check_eq("race_len", rc, exp_len[rr]);
                    r++;
                    rc = 0;
                end
                // Levels outside a race must be ignored.
                done_a = 1'($urandom_range(0, 1));
                done_b = 1'($urandom_range(0, 1));
            end
            if (resp_valid) begin
                check_eq("response", response, exp_resp);
                check_eq("err", err, exp_err);
                check_eq("eval_cycles", cyc, exp_cycles);
                check_eq("race_count", r, NRACE);
                check_eq("clr_count", nclr, NRACE);
                got   = 1'b1;
                start = 1'b0;
            end else begin
                // Start pulses while busy must be ignored.
                start     = 1'($urandom_range(0, 1));
                challenge = 16'($urandom);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start  = 1'b0;
        done_a = 1'b0;
        done_b = 1'b0;
        check_eq("resp_seen", got, 1);
        check_eq("valid_once", resp_valid, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("resp_hold", response, exp_resp);
        last_resp = exp_resp;
    endtask

    initial begin
        logic [15:0] s;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_ro_en", ro_en, 0);
        check_eq("reset_ctr_clr", ctr_clr, 0);
        check_eq("reset_valid", resp_valid, 0);
        check_eq("reset_response", response, 0);
        check_eq("reset_err", err, 0);
        check_eq("reset_sel", {sel_b, sel_a}, 0);
        rst       = 1'b0;
        last_resp = 8'h00;
        @(posedge clk);
        #1;

        // A always wins, 10 cycles into each race.
        plan_all(0, 10);
        run_eval(16'hACE1, -1);
        check_eq("t1_all_ones", response, 8'hFF);
        check_eq("t1_no_err", err, 0);

        // B always wins.
        plan_all(1, -1);
        run_eval(16'hACE1, -1);
        check_eq("t2_all_zero", response, 8'h00);

        // Zero challenge and a colliding first pair.
        plan_random(1'b0);
        run_eval(16'h0000, -1);
        plan_random(1'b0);
        run_eval(16'h0055, -1);

        // Tie on bit 3.
        plan_random(1'b0);
        for (int k = 0; k < REPS; k++) kind[3 * REPS + k] = 2;
        s = 16'($urandom);
        run_eval(s, -1);
        check_eq("t4_bit3", response[3], 0);
        check_eq("t4_err", err, 1);

        // Timeout on bit 0.
        plan_random(1'b0);
        for (int k = 0; k < REPS; k++) kind[k] = 3;
        s = 16'($urandom);
        run_eval(s, -1);
        check_eq("t5_bit0", response[0], 0);
        check_eq("t5_err", err, 1);

        // Reset during race of bit 5, then a clean evaluation.
        plan_random(1'b0);
        s = 16'($urandom);
        run_eval(s, 5 * REPS);
        plan_random(1'b0);
        s = 16'($urandom);
        run_eval(s, -1);

        for (int i = 0; i < 6; i++) begin
            plan_random(1'b1);
            s = 16'($urandom);
            run_eval(s, -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/puf_race_ctrl.md
Name: puf_race_ctrl

Overview:
Sequences the ring-oscillator race counters of the RO-based PUF. From a 16-bit challenge it derives a series of RO pairs, clears and arms the two race counters, and records which counter reaches its threshold first as one response bit. It assembles RESP_BITS bits into a response word with a valid pulse. It sits between the top-level I/O and the two edge counters and the RO select muxes.

Parameters:
NUM_RO, 16, number of ring oscillators; SEL_W = clog2(NUM_RO)
RESP_BITS, 8, response bits per challenge
SETTLE_CYCLES, 4, cycles with ROs disabled after a mux change
TIMEOUT, 65535, maximum RACE cycles before a forced decision

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin evaluation; sampled only in IDLE
challenge  in  16  LFSR seed; captured on accepted start
done_a  in  1  counter A reached threshold
done_b  in  1  counter B reached threshold
sel_a  out  SEL_W  RO index routed to counter A
sel_b  out  SEL_W  RO index routed to counter B
ro_en  out  1  enable for both ROs and counters
ctr_clr  out  1  counter clear pulse
busy  out  1  high outside IDLE
resp_valid  out  1  one-cycle pulse, response valid
response  out  RESP_BITS  response word, held until the next resp_valid
err  out  1  sticky per evaluation: tie or timeout occurred

Behaviour:
- Reset: state IDLE; all outputs 0; LFSR 0; bit index 0.
- Start is accepted in IDLE when start=1 and rst=0. The LFSR loads challenge, or 16'h0001 if challenge==0. err clears. Start is ignored while busy.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advanced once per bit in NEXT.
- Pair derivation: sel_a = lfsr[SEL_W-1:0]; sel_b = lfsr[2*SEL_W-1:SEL_W]. If sel_b==sel_a, then sel_b = sel_a ^ 1. sel_a and sel_b are registered and change only in NEXT and on start.
- FSM:
  - IDLE: on start, go to CLEAR.
  - CLEAR: 1 cycle; ctr_clr=1, ro_en=0; go to SETTLE.
  - SETTLE: SETTLE_CYCLES cycles with ro_en=0; go to RACE.
  - RACE: ro_en=1; the cycle counter increments from 0. Leave when done_a | done_b, or when the counter reaches TIMEOUT-1.
  - RECORD: 1 cycle, ro_en=0. bit = done_a & ~done_b. A tie (both done in the same cycle) gives bit=0 and sets err. A timeout gives bit=0 and sets err. The bit is shifted into response[idx] (LSB first).
  - NEXT: advance the LFSR and re-derive the pair; idx++. If idx==RESP_BITS-1 before the increment, go to DONE; otherwise go to CLEAR.
  - DONE: resp_valid=1 for 1 cycle; the response register updates in the same cycle; go to IDLE.
- Latency per bit without timeout = 1 + SETTLE_CYCLES + race length + 2.
- done_a and done_b are sampled only in RACE; any level outside RACE is ignored.
- rst mid-evaluation: return to IDLE next cycle. ro_en=0, response=0, and no resp_valid is produced.
- The start/done_* inputs and the counter done outputs are synchronous to clk. The counters synchronise RO edges internally.

Optional Feature:
PUF_MAJORITY_EN
- When defined: each bit is raced 3 times on the same pair (CLEAR→SETTLE→RACE→RECORD ×3). The recorded bit is the majority of the 3 outcomes. err is set if any of the 3 races tied or timed out.
- When undefined: a single race per bit, as described above.
- Ports are identical in both builds.

Decomposition:
- puf_pkg: state enum (IDLE, CLEAR, SETTLE, RACE, RECORD, NEXT, DONE), LFSR tap constant, seed-substitution constant 16'h0001, and SEL_W derivation function.
- One sub-module, puf_lfsr: load/advance, 16-bit state output.
- FSM, pair derivation and response shift register remain in puf_race_ctrl.

Test Plan:
1. challenge=16'hACE1, done_a asserted 10 cycles into each RACE → response=8'hFF, err=0, resp_valid exactly once. Each bit takes 1+4+11+2 cycles.
2. Same challenge, done_b first on every race → response=8'h00, err=0. Check the sel_a/sel_b sequence against a reference LFSR model, with sel_a!=sel_b on every pair.
3. challenge=16'h0000 → LFSR seeded with 16'h0001. The first pair is derived from 16'h0001 with sel_b forced to sel_a^1 when the two indices collide.
4. done_a and done_b asserted in the same cycle on bit 3 → response[3]=0 and err=1.
5. Neither done asserted on bit 0, TIMEOUT=20 → RACE lasts exactly 20 cycles, response[0]=0, err=1. Evaluation continues to completion.
6. rst asserted during RACE of bit 5 → next cycle: IDLE, busy=0, ro_en=0, response=0, no resp_valid. A new start then runs a full, clean evaluation.
